// File: rtl/acc_cmd_queue.sv
// acc_cmd_queue: command queue and issue sequencer in front of the 8-bit
// accumulator ALU. It buffers host (op, operand, repeat) commands in a circular
// buffer and issues each command rpt+1 times, one issue per accepted cycle.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   flush             synchronous clear of queue and repeat counter
//   pause             suppresses issue while high; queue contents held
//   cmd_valid/ready   host command handshake; cmd_op, cmd_data, cmd_rpt payload
//   issue_valid/ready accumulator handshake; issue_op, issue_data, issue_last
//   level, busy       stored command count and level!=0
module acc_cmd_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          pause,
    input  logic          cmd_valid,
    input  logic [1:0]    cmd_op,
    input  logic [7:0]    cmd_data,
    input  logic [1:0]    cmd_rpt,
    output logic          cmd_ready,
    output logic          issue_valid,
    output logic [1:0]    issue_op,
    output logic [7:0]    issue_data,
    output logic          issue_last,
    input  logic          issue_ready,
    output logic [CW-1:0] level,
    output logic          busy
);

    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_HOLD  = 2'd2
    } state_e;

    typedef struct packed {
        logic [1:0] op;
        logic [7:0] data;
        logic [1:0] rpt;
    } entry_t;

    state_e          state_q, state_d;
    entry_t          mem_q [DEPTH];
    entry_t          mem_d [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [1:0]      rcnt_q, rcnt_d;

    entry_t          head;
    logic            push;
    logic            issue_fire;
    logic            pop;

    // Handshake decode; reset and flush block both transfers in their cycle.
    assign head        = mem_q[rd_ptr_q];
    assign cmd_ready   = rst_n && !flush && (count_q != CW'(DEPTH));
    assign issue_valid = rst_n && !flush && (state_q == ST_ISSUE);
    assign issue_op    = head.op;
    assign issue_data  = head.data;
    assign issue_last  = (rcnt_q == head.rpt);
    assign level       = count_q;
    assign busy        = (count_q != '0);

    assign push       = cmd_valid && cmd_ready;
    assign issue_fire = issue_valid && issue_ready;
    assign pop        = issue_fire && issue_last;

    // Storage, pointers, count and repeat counter next-state.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        rcnt_d   = rcnt_q;

        if (push) begin
            mem_d[wr_ptr_q] = '{op: cmd_op, data: cmd_data, rpt: cmd_rpt};
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end

        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        if (issue_fire) begin
            rcnt_d = issue_last ? 2'd0 : rcnt_q + 2'd1;
        end

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            rcnt_d   = '0;
        end
    end

    // Issue FSM next-state; looks at count_d so a push is issued the next cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (count_d != '0) begin
                    state_d = pause ? ST_HOLD : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (count_d == '0) begin
                    state_d = ST_IDLE;
                end else if (pause) begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (!pause) begin
                    state_d = ST_ISSUE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (flush) begin
            state_d = ST_IDLE;
        end
    end

    // State registers; reset also clears storage so idle outputs read zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            rcnt_q   <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            rcnt_q   <= rcnt_d;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

endmodule
